// File: rtl/cab_slave_if.sv
// CAB phase link plus local register bus, bundled for the CAB slave endpoint.
interface cab_slave_if;
  logic        cab_xxi_sreq;
  logic [15:0] cab_xxi_swdata;
  logic        xxi_cab_sreq_rdy;
  logic        xxi_cab_sdn;
  logic [15:0] xxi_cab_srdata;
  logic        xxo_reg_req;
  logic [15:0] xxo_reg_addr;
  logic        xxo_reg_lan;
  logic        xxo_reg_wr;
  logic [31:0] xxo_reg_wdata;
  logic        reg_xxo_rdy;
  logic        reg_xxo_dn;
  logic [31:0] reg_xxo_rdata;
  logic        cab_s_to_err;

  modport slave (
    input  cab_xxi_sreq, cab_xxi_swdata, reg_xxo_rdy, reg_xxo_dn, reg_xxo_rdata,
    output xxi_cab_sreq_rdy, xxi_cab_sdn, xxi_cab_srdata, xxo_reg_req, xxo_reg_addr,
           xxo_reg_lan, xxo_reg_wr, xxo_reg_wdata, cab_s_to_err
  );

  modport master (
    output cab_xxi_sreq, cab_xxi_swdata, reg_xxo_rdy, reg_xxo_dn, reg_xxo_rdata,
    input  xxi_cab_sreq_rdy, xxi_cab_sdn, xxi_cab_srdata, xxo_reg_req, xxo_reg_addr,
           xxo_reg_lan, xxo_reg_wr, xxo_reg_wdata, cab_s_to_err
  );
endinterface

// File: rtl/cab_slave.sv
// CAB slave: collects 16-bit address/data phases into one 32-bit register access and
// returns read data as two 16-bit halves, with a read-wait timeout.
module cab_slave #(
  parameter int          TO_CYC  = 255,
  parameter logic [31:0] TO_DATA = 32'hDEAD_BEEF
) (
  input logic        clk,
  input logic        rst_n,
  cab_slave_if.slave bus
);
  localparam logic [6:0] S_ADDR  = 7'b0000001;
  localparam logic [6:0] S_WDAT0 = 7'b0000010;
  localparam logic [6:0] S_WDAT1 = 7'b0000100;
  localparam logic [6:0] S_REQ   = 7'b0001000;
  localparam logic [6:0] S_RWAIT = 7'b0010000;
  localparam logic [6:0] S_RDAT0 = 7'b0100000;
  localparam logic [6:0] S_RDAT1 = 7'b1000000;

  localparam logic [15:0] TO_LAST = 16'(TO_CYC - 1);

  logic [6:0]  state_q, state_d;
  logic [13:0] addr_q;
  logic        lan_q, wr_q, err_q;
  logic [31:0] wdata_q, rdata_q;
  logic [15:0] cnt_q;
  logic        to_hit;

  assign to_hit = (cnt_q == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_ADDR;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_ADDR:  if (bus.cab_xxi_sreq) state_d = bus.cab_xxi_swdata[0] ? S_WDAT0 : S_REQ;
      S_WDAT0: if (bus.cab_xxi_sreq) state_d = S_WDAT1;
      S_WDAT1: if (bus.cab_xxi_sreq) state_d = S_REQ;
      S_REQ:   if (bus.reg_xxo_rdy)  state_d = wr_q ? S_ADDR : S_RWAIT;
      S_RWAIT: if (bus.reg_xxo_dn || to_hit) state_d = S_RDAT0;
      S_RDAT0: state_d = S_RDAT1;
      S_RDAT1: state_d = S_ADDR;
      default: state_d = S_ADDR;
    endcase
  end

  // Outputs decode straight from the registered state; illegal encodings leave all low.
  always_comb begin
    bus.xxi_cab_sreq_rdy = 1'b0;
    bus.xxi_cab_sdn      = 1'b0;
    bus.xxi_cab_srdata   = 16'h0;
    bus.xxo_reg_req      = 1'b0;
    case (state_q)
      S_ADDR, S_WDAT0, S_WDAT1: bus.xxi_cab_sreq_rdy = 1'b1;
      S_REQ:   bus.xxo_reg_req = 1'b1;
      S_RDAT0: begin
        bus.xxi_cab_sdn    = 1'b1;
        bus.xxi_cab_srdata = rdata_q[15:0];
      end
      S_RDAT1: begin
        bus.xxi_cab_sdn    = 1'b1;
        bus.xxi_cab_srdata = rdata_q[31:16];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      lan_q   <= 1'b0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_ADDR: if (bus.cab_xxi_sreq) begin
          addr_q <= bus.cab_xxi_swdata[15:2];
          lan_q  <= bus.cab_xxi_swdata[1];
          wr_q   <= bus.cab_xxi_swdata[0];
        end
        S_WDAT0: if (bus.cab_xxi_sreq) wdata_q[15:0]  <= bus.cab_xxi_swdata;
        S_WDAT1: if (bus.cab_xxi_sreq) wdata_q[31:16] <= bus.cab_xxi_swdata;
        S_REQ:   if (bus.reg_xxo_rdy && !wr_q) cnt_q <= '0;
        S_RWAIT: begin
          // Real data in the expiry cycle takes priority over the timeout.
          if (bus.reg_xxo_dn) rdata_q <= bus.reg_xxo_rdata;
          else if (to_hit) begin
            rdata_q <= TO_DATA;
            err_q   <= 1'b1;
          end else cnt_q <= cnt_q + 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.xxo_reg_addr  = {addr_q, 2'b00};
  assign bus.xxo_reg_lan   = lan_q;
  assign bus.xxo_reg_wr    = wr_q;
  assign bus.xxo_reg_wdata = wdata_q;
  assign bus.cab_s_to_err  = err_q;
endmodule

// File: tb/tb_cab_slave.sv
// Directed bench for cab_slave: write, read, backpressure, timeout, reset and back-to-back.
module tb_cab_slave;
  logic clk;
  logic rst_n;
  int   checks;
  int   fails;

  cab_slave_if b();

  cab_slave #(.TO_CYC(8), .TO_DATA(32'hDEAD_BEEF)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one phase and hold it until the slave takes it (bounded).
  task automatic send_phase(input logic [15:0] w);
    int n;
    n = 0;
    b.cab_xxi_sreq   = 1'b1;
    b.cab_xxi_swdata = w;
    while (!b.xxi_cab_sreq_rdy && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 50) begin fails++; $display("FAIL phase_accept_timeout got=stalled exp=accepted w=%h", w); end
    tick();
    b.cab_xxi_sreq   = 1'b0;
    b.cab_xxi_swdata = 16'hFFFF;
  endtask

  task automatic do_reset();
    #1 rst_n = 1'b0;
    b.cab_xxi_sreq = 1'b0;
    b.reg_xxo_rdy  = 1'b0;
    b.reg_xxo_dn   = 1'b0;
    #12 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (b.xxi_cab_sreq_rdy !== 1'b1) begin fails++; $display("FAIL rst_sreq_rdy got=%h exp=1", b.xxi_cab_sreq_rdy); end
    checks++; if (b.xxi_cab_sdn !== 1'b0) begin fails++; $display("FAIL rst_sdn got=%h exp=0", b.xxi_cab_sdn); end
    checks++; if (b.xxi_cab_srdata !== 16'h0) begin fails++; $display("FAIL rst_srdata got=%h exp=0", b.xxi_cab_srdata); end
    checks++; if (b.xxo_reg_req !== 1'b0) begin fails++; $display("FAIL rst_reg_req got=%h exp=0", b.xxo_reg_req); end
    checks++; if (b.xxo_reg_addr !== 16'h0) begin fails++; $display("FAIL rst_reg_addr got=%h exp=0", b.xxo_reg_addr); end
    checks++; if ({b.xxo_reg_lan, b.xxo_reg_wr} !== 2'b00) begin fails++; $display("FAIL rst_lan_wr got=%b exp=00", {b.xxo_reg_lan, b.xxo_reg_wr}); end
    checks++; if (b.xxo_reg_wdata !== 32'h0) begin fails++; $display("FAIL rst_wdata got=%h exp=0", b.xxo_reg_wdata); end
    checks++; if (b.cab_s_to_err !== 1'b0) begin fails++; $display("FAIL rst_to_err got=%h exp=0", b.cab_s_to_err); end
  endtask

  task automatic test_write();
    send_phase(16'hC005);
    send_phase(16'h5678);
    send_phase(16'h1234);
    checks++; if (b.xxo_reg_req !== 1'b1) begin fails++; $display("FAIL wr_req got=%h exp=1", b.xxo_reg_req); end
    checks++; if (b.xxo_reg_addr !== 16'hC004) begin fails++; $display("FAIL wr_addr got=%h exp=c004", b.xxo_reg_addr); end
    checks++; if ({b.xxo_reg_lan, b.xxo_reg_wr} !== 2'b01) begin fails++; $display("FAIL wr_lan_wr got=%b exp=01", {b.xxo_reg_lan, b.xxo_reg_wr}); end
    checks++; if (b.xxo_reg_wdata !== 32'h1234_5678) begin fails++; $display("FAIL wr_wdata got=%h exp=12345678", b.xxo_reg_wdata); end
    checks++; if (b.xxi_cab_sreq_rdy !== 1'b0) begin fails++; $display("FAIL wr_stall got=%h exp=0", b.xxi_cab_sreq_rdy); end
    // Stray read-done during a write must be ignored.
    b.reg_xxo_dn = 1'b1; b.reg_xxo_rdata = 32'hFFFF_FFFF;
    tick();
    b.reg_xxo_rdy = 1'b1;
    tick();
    b.reg_xxo_rdy = 1'b0;
    checks++; if (b.xxo_reg_req !== 1'b0 || b.xxi_cab_sreq_rdy !== 1'b1) begin fails++; $display("FAIL wr_done got=req%h/rdy%h exp=req0/rdy1", b.xxo_reg_req, b.xxi_cab_sreq_rdy); end
    for (int i = 0; i < 2; i++) begin
      checks++; if (b.xxi_cab_sdn !== 1'b0) begin fails++; $display("FAIL wr_no_sdn got=%h exp=0 cyc=%0d", b.xxi_cab_sdn, i); end
      tick();
    end
    b.reg_xxo_dn = 1'b0;
  endtask

  task automatic test_read();
    send_phase(16'h0102);
    checks++; if (b.xxo_reg_req !== 1'b1 || b.xxo_reg_addr !== 16'h0100) begin fails++; $display("FAIL rd_req got=%h/%h exp=1/0100", b.xxo_reg_req, b.xxo_reg_addr); end
    checks++; if ({b.xxo_reg_lan, b.xxo_reg_wr} !== 2'b10) begin fails++; $display("FAIL rd_lan_wr got=%b exp=10", {b.xxo_reg_lan, b.xxo_reg_wr}); end
    b.reg_xxo_rdy = 1'b1;
    tick();
    b.reg_xxo_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (b.xxi_cab_sreq_rdy !== 1'b0 || b.xxi_cab_sdn !== 1'b0 || b.xxo_reg_req !== 1'b0) begin fails++; $display("FAIL rd_wait got=rdy%h/sdn%h/req%h exp=0/0/0 cyc=%0d", b.xxi_cab_sreq_rdy, b.xxi_cab_sdn, b.xxo_reg_req, i); end
      if (i == 2) begin b.reg_xxo_dn = 1'b1; b.reg_xxo_rdata = 32'hA5A5_0F0F; end
      tick();
    end
    b.reg_xxo_dn = 1'b0;
    checks++; if (b.xxi_cab_sdn !== 1'b1 || b.xxi_cab_srdata !== 16'h0F0F || b.xxi_cab_sreq_rdy !== 1'b0) begin fails++; $display("FAIL rd_half0 got=%h/%h/rdy%h exp=1/0f0f/rdy0", b.xxi_cab_sdn, b.xxi_cab_srdata, b.xxi_cab_sreq_rdy); end
    tick();
    checks++; if (b.xxi_cab_sdn !== 1'b1 || b.xxi_cab_srdata !== 16'hA5A5 || b.xxi_cab_sreq_rdy !== 1'b0) begin fails++; $display("FAIL rd_half1 got=%h/%h/rdy%h exp=1/a5a5/rdy0", b.xxi_cab_sdn, b.xxi_cab_srdata, b.xxi_cab_sreq_rdy); end
    tick();
    checks++; if (b.xxi_cab_sdn !== 1'b0 || b.xxi_cab_srdata !== 16'h0 || b.xxi_cab_sreq_rdy !== 1'b1) begin fails++; $display("FAIL rd_end got=%h/%h/rdy%h exp=0/0000/rdy1", b.xxi_cab_sdn, b.xxi_cab_srdata, b.xxi_cab_sreq_rdy); end
    checks++; if (b.cab_s_to_err !== 1'b0) begin fails++; $display("FAIL rd_to_err got=%h exp=0", b.cab_s_to_err); end
  endtask

  task automatic test_backpressure();
    send_phase(16'h0011);
    for (int i = 0; i < 3; i++) tick();
    checks++; if (b.xxi_cab_sreq_rdy !== 1'b1 || b.xxo_reg_req !== 1'b0) begin fails++; $display("FAIL bp_gap got=rdy%h/req%h exp=1/0", b.xxi_cab_sreq_rdy, b.xxo_reg_req); end
    send_phase(16'h1111);
    for (int i = 0; i < 2; i++) tick();
    checks++; if (b.xxo_reg_wdata !== 32'h1234_1111) begin fails++; $display("FAIL bp_lo got=%h exp=12341111", b.xxo_reg_wdata); end
    send_phase(16'h2222);
    // Next address phase waits while the register bus stalls.
    b.cab_xxi_sreq = 1'b1; b.cab_xxi_swdata = 16'h0021;
    for (int i = 0; i < 6; i++) begin
      checks++; if (b.xxo_reg_req !== 1'b1 || b.xxo_reg_addr !== 16'h0010 || b.xxo_reg_wdata !== 32'h2222_1111) begin fails++; $display("FAIL bp_hold got=req%h/%h/%h exp=1/0010/22221111 cyc=%0d", b.xxo_reg_req, b.xxo_reg_addr, b.xxo_reg_wdata, i); end
      if (i == 5) b.reg_xxo_rdy = 1'b1;
      tick();
    end
    b.reg_xxo_rdy = 1'b0;
    checks++; if (b.xxi_cab_sreq_rdy !== 1'b1 || b.xxo_reg_req !== 1'b0 || b.xxo_reg_addr !== 16'h0010) begin fails++; $display("FAIL bp_idle got=rdy%h/req%h/%h exp=1/0/0010", b.xxi_cab_sreq_rdy, b.xxo_reg_req, b.xxo_reg_addr); end
    tick();
    b.cab_xxi_sreq = 1'b0;
    checks++; if (b.xxo_reg_addr !== 16'h0020 || b.xxo_reg_wr !== 1'b1 || b.xxi_cab_sreq_rdy !== 1'b1) begin fails++; $display("FAIL bp_next got=%h/wr%h/rdy%h exp=0020/1/1", b.xxo_reg_addr, b.xxo_reg_wr, b.xxi_cab_sreq_rdy); end
    send_phase(16'h3333);
    send_phase(16'h4444);
    checks++; if (b.xxo_reg_wdata !== 32'h4444_3333 || b.xxo_reg_req !== 1'b1) begin fails++; $display("FAIL bp_next_data got=%h/req%h exp=44443333/1", b.xxo_reg_wdata, b.xxo_reg_req); end
    b.reg_xxo_rdy = 1'b1;
    tick();
    b.reg_xxo_rdy = 1'b0;
  endtask

  task automatic test_timeout();
    send_phase(16'h0202);
    b.reg_xxo_rdy = 1'b1;
    tick();
    b.reg_xxo_rdy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++; if (b.xxi_cab_sdn !== 1'b0 || b.cab_s_to_err !== 1'b0) begin fails++; $display("FAIL to_wait got=sdn%h/err%h exp=0/0 cyc=%0d", b.xxi_cab_sdn, b.cab_s_to_err, i); end
      tick();
    end
    checks++; if (b.xxi_cab_sdn !== 1'b1 || b.xxi_cab_srdata !== 16'hBEEF || b.cab_s_to_err !== 1'b1) begin fails++; $display("FAIL to_half0 got=%h/%h/err%h exp=1/beef/1", b.xxi_cab_sdn, b.xxi_cab_srdata, b.cab_s_to_err); end
    tick();
    checks++; if (b.xxi_cab_sdn !== 1'b1 || b.xxi_cab_srdata !== 16'hDEAD) begin fails++; $display("FAIL to_half1 got=%h/%h exp=1/dead", b.xxi_cab_sdn, b.xxi_cab_srdata); end
    tick();
    checks++; if (b.cab_s_to_err !== 1'b1 || b.xxi_cab_sreq_rdy !== 1'b1) begin fails++; $display("FAIL to_sticky got=err%h/rdy%h exp=1/1", b.cab_s_to_err, b.xxi_cab_sreq_rdy); end
    do_reset();
    checks++; if (b.cab_s_to_err !== 1'b0) begin fails++; $display("FAIL to_err_clr got=%h exp=0", b.cab_s_to_err); end
    // Data arriving in the expiry cycle wins.
    send_phase(16'h0202);
    b.reg_xxo_rdy = 1'b1;
    tick();
    b.reg_xxo_rdy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) begin b.reg_xxo_dn = 1'b1; b.reg_xxo_rdata = 32'h1357_9BDF; end
      tick();
    end
    b.reg_xxo_dn = 1'b0;
    checks++; if (b.xxi_cab_sdn !== 1'b1 || b.xxi_cab_srdata !== 16'h9BDF || b.cab_s_to_err !== 1'b0) begin fails++; $display("FAIL to_edge0 got=%h/%h/err%h exp=1/9bdf/0", b.xxi_cab_sdn, b.xxi_cab_srdata, b.cab_s_to_err); end
    tick();
    checks++; if (b.xxi_cab_srdata !== 16'h1357 || b.cab_s_to_err !== 1'b0) begin fails++; $display("FAIL to_edge1 got=%h/err%h exp=1357/0", b.xxi_cab_srdata, b.cab_s_to_err); end
    tick();
  endtask

  task automatic test_reset_mid();
    send_phase(16'h0041);
    send_phase(16'h9999);
    #1 rst_n = 1'b0;
    #1;
    checks++; if (b.xxi_cab_sreq_rdy !== 1'b1 || b.xxo_reg_addr !== 16'h0 || b.xxo_reg_wr !== 1'b0 || b.xxo_reg_wdata !== 32'h0 || b.xxo_reg_req !== 1'b0) begin fails++; $display("FAIL rm_wdat1 got=rdy%h/%h/wr%h/%h/req%h exp=1/0000/0/00000000/0", b.xxi_cab_sreq_rdy, b.xxo_reg_addr, b.xxo_reg_wr, b.xxo_reg_wdata, b.xxo_reg_req); end
    @(negedge clk) rst_n = 1'b1;
    tick();
    send_phase(16'h0082);
    b.reg_xxo_rdy = 1'b1;
    tick();
    b.reg_xxo_rdy = 1'b0;
    tick();
    #1 rst_n = 1'b0;
    #1;
    checks++; if (b.xxi_cab_sreq_rdy !== 1'b1 || b.xxi_cab_sdn !== 1'b0 || b.xxo_reg_lan !== 1'b0 || b.xxo_reg_addr !== 16'h0 || b.cab_s_to_err !== 1'b0) begin fails++; $display("FAIL rm_rwait got=rdy%h/sdn%h/lan%h/%h/err%h exp=1/0/0/0000/0", b.xxi_cab_sreq_rdy, b.xxi_cab_sdn, b.xxo_reg_lan, b.xxo_reg_addr, b.cab_s_to_err); end
    @(negedge clk) rst_n = 1'b1;
    tick();
    send_phase(16'h0105);
    send_phase(16'hAAAA);
    send_phase(16'h5555);
    checks++; if (b.xxo_reg_req !== 1'b1 || b.xxo_reg_addr !== 16'h0104 || b.xxo_reg_wdata !== 32'h5555_AAAA) begin fails++; $display("FAIL rm_after got=req%h/%h/%h exp=1/0104/5555aaaa", b.xxo_reg_req, b.xxo_reg_addr, b.xxo_reg_wdata); end
    b.reg_xxo_rdy = 1'b1;
    tick();
    b.reg_xxo_rdy = 1'b0;
  endtask

  task automatic test_back_to_back();
    b.cab_xxi_sreq = 1'b1; b.cab_xxi_swdata = 16'h0302;
    tick();
    b.cab_xxi_swdata = 16'h0401;
    checks++; if (b.xxo_reg_req !== 1'b1 || b.xxo_reg_addr !== 16'h0300 || b.xxo_reg_wr !== 1'b0) begin fails++; $display("FAIL b2b_rd got=req%h/%h/wr%h exp=1/0300/0", b.xxo_reg_req, b.xxo_reg_addr, b.xxo_reg_wr); end
    b.reg_xxo_rdy = 1'b1;
    tick();
    b.reg_xxo_rdy = 1'b0;
    b.reg_xxo_dn = 1'b1; b.reg_xxo_rdata = 32'hCAFE_F00D;
    tick();
    b.reg_xxo_dn = 1'b0;
    checks++; if (b.xxi_cab_srdata !== 16'hF00D || b.xxo_reg_addr !== 16'h0300 || b.xxi_cab_sreq_rdy !== 1'b0) begin fails++; $display("FAIL b2b_h0 got=%h/%h/rdy%h exp=f00d/0300/0", b.xxi_cab_srdata, b.xxo_reg_addr, b.xxi_cab_sreq_rdy); end
    tick();
    checks++; if (b.xxi_cab_srdata !== 16'hCAFE || b.xxo_reg_addr !== 16'h0300 || b.xxi_cab_sreq_rdy !== 1'b0) begin fails++; $display("FAIL b2b_h1 got=%h/%h/rdy%h exp=cafe/0300/0", b.xxi_cab_srdata, b.xxo_reg_addr, b.xxi_cab_sreq_rdy); end
    tick();
    checks++; if (b.xxi_cab_sreq_rdy !== 1'b1 || b.xxo_reg_addr !== 16'h0300) begin fails++; $display("FAIL b2b_idle got=rdy%h/%h exp=1/0300", b.xxi_cab_sreq_rdy, b.xxo_reg_addr); end
    tick();
    checks++; if (b.xxo_reg_addr !== 16'h0400 || b.xxo_reg_wr !== 1'b1) begin fails++; $display("FAIL b2b_wr got=%h/wr%h exp=0400/1", b.xxo_reg_addr, b.xxo_reg_wr); end
    b.cab_xxi_swdata = 16'h7777;
    tick();
    b.cab_xxi_swdata = 16'h8888;
    tick();
    b.cab_xxi_sreq = 1'b0;
    checks++; if (b.xxo_reg_req !== 1'b1 || b.xxo_reg_wdata !== 32'h8888_7777) begin fails++; $display("FAIL b2b_wdata got=req%h/%h exp=1/88887777", b.xxo_reg_req, b.xxo_reg_wdata); end
    b.reg_xxo_rdy = 1'b1;
    tick();
    b.reg_xxo_rdy = 1'b0;
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    rst_n  = 1'b0;
    b.cab_xxi_sreq   = 1'b0;
    b.cab_xxi_swdata = 16'h0;
    b.reg_xxo_rdy    = 1'b0;
    b.reg_xxo_dn     = 1'b0;
    b.reg_xxo_rdata  = 32'h0;
    test_reset();
    test_write();
    test_read();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
